// File: rtl/vpe_serial_mac.sv
// Bit-serial packed-SIMD vector PE: add/sub, MSB-first serial multiply, MAC and
// running-sum MAC with optional per-lane signed saturation.
module vpe_serial_mac #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [1:0]      sew,
  input  logic            vp,
  input  logic [3:0]      prec,
  input  logic            sat,
  input  logic            clr,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [XLEN-1:0] opC,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] peout
);
  localparam int NB = XLEN / 8;
  localparam logic [XLEN-1:0] ONE = 1;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2,
                         OP_MAC = 3'd3, OP_MACR = 3'd4;

  typedef enum logic [1:0] {IDLE, SHIFT, FIN, OUT} state_t;
  state_t state, state_n;

  // Lanes are tracked as a byte mask: lm = bytes-per-lane - 1, so a byte i
  // starts a lane when (i & lm) == 0 and its lane's top byte is (i | lm).
  function automatic logic [XLEN-1:0] lane_add(input logic [XLEN-1:0] x, y,
                                               input logic cin,
                                               input logic [2:0] lm,
                                               input logic clamp);
    logic [XLEN-1:0] r, raw;
    logic [8:0] s;
    logic c, sx, sy, sr;
    int top;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if ((i & int'(lm)) == 0) c = cin;
      s = {1'b0, x[i*8 +: 8]} + {1'b0, y[i*8 +: 8]} + {8'd0, c};
      r[i*8 +: 8] = s[7:0];
      c = s[8];
    end
    raw = r;
    if (clamp) begin
      for (int i = 0; i < NB; i++) begin
        top = (i | int'(lm)) * 8 + 7;
        sx = |(x & (ONE << top));
        sy = |(y & (ONE << top));
        sr = |(raw & (ONE << top));
        if (sx == sy && sr != sx)
          r[i*8 +: 8] = ((i | int'(lm)) == i) ? (sx ? 8'h80 : 8'h7F) : {8{~sx}};
      end
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] lane_shl(input logic [XLEN-1:0] x, input logic [2:0] lm);
    logic [XLEN-1:0] r;
    r = x << 1;
    for (int i = 0; i < NB; i++)
      if ((i & int'(lm)) == 0) r[i*8 +: 1] = 1'b0;
    return r;
  endfunction

  function automatic logic lane_bit(input logic [XLEN-1:0] b, input logic [2:0] lm,
                                    input int pos, input int i);
    int idx;
    idx = ((i & ~int'(lm)) + (pos >> 3)) * 8 + (pos & 7);
    return |(b & (ONE << idx));
  endfunction

  function automatic logic [XLEN-1:0] sext_p(input logic [XLEN-1:0] b, input int p);
    logic [XLEN-1:0] r;
    logic [7:0] bb, m;
    for (int i = 0; i < NB; i++) begin
      bb = b[i*8 +: 8];
      m  = 8'hFF << p;
      r[i*8 +: 8] = (|(bb & (8'h01 << (p - 1)))) ? (bb | m) : (bb & ~m);
    end
    return r;
  endfunction

  logic [2:0]       op_q, lm_q, lm_in;
  logic             vp_q, sat_q, clr_q, is_mul_in, accept, first, p1;
  logic [CNT_W-1:0] cnt_q, nbits_q, n_in;
  logic [3:0]       p_in;
  logic [XLEN-1:0]  a_q, b_q, c_q, acc_q, run_q;
  logic [XLEN-1:0]  neg_a, addend, first_v, acc_n, bx, fx, fy, fin_res;
  logic             fcin;
  logic [NB-1:0]    bsel;
  int               pos;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign is_mul_in = (op == OP_MUL) || (op == OP_MAC) || (op == OP_MACR);
  assign p_in      = (prec == 4'd0) ? 4'd8 : prec;

  always_comb begin
    lm_in = 3'd0;
    n_in  = CNT_W'(8);
    if (vp) n_in = CNT_W'(p_in);
    else begin
      case (sew)
        2'd1:    begin lm_in = 3'd1; n_in = CNT_W'(16); end
        2'd2:    begin lm_in = 3'd3; n_in = CNT_W'(32); end
        2'd3:    begin lm_in = (XLEN == 64) ? 3'd7 : 3'd3; n_in = CNT_W'(XLEN); end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = is_mul_in ? SHIFT : FIN;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_n = FIN;
      FIN:     state_n = OUT;
      OUT:     if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One serial step: the first bit carries negative weight (sign bit), except
  // the binarised 1-bit mode where a 0 bit stands for +1.
  always_comb begin
    pos   = (cnt_q == '0) ? 0 : int'(cnt_q) - 1;
    first = (cnt_q == nbits_q);
    p1    = vp_q && (nbits_q == CNT_W'(1));
    neg_a = lane_add(~a_q, '0, 1'b1, lm_q, 1'b0);
    for (int i = 0; i < NB; i++) begin
      bsel[i] = lane_bit(b_q, lm_q, pos, i);
      addend[i*8 +: 8]  = bsel[i] ? a_q[i*8 +: 8] : 8'h00;
      first_v[i*8 +: 8] = bsel[i] ? neg_a[i*8 +: 8] : (p1 ? a_q[i*8 +: 8] : 8'h00);
    end
    acc_n = first ? first_v : lane_add(lane_shl(acc_q, lm_q), addend, 1'b0, lm_q, 1'b0);
  end

  always_comb begin
    bx   = vp_q ? sext_p(b_q, int'(nbits_q)) : b_q;
    fx   = '0;
    fy   = '0;
    fcin = 1'b0;
    case (op_q)
      OP_ADD:  begin fx = a_q;   fy = bx; end
      OP_SUB:  begin fx = a_q;   fy = ~bx; fcin = 1'b1; end
      OP_MAC:  begin fx = acc_q; fy = c_q; end
      OP_MACR: begin fx = acc_q; fy = clr_q ? '0 : run_q; end
      default: ;
    endcase
    fin_res = lane_add(fx, fy, fcin, lm_q, sat_q);
    if (op_q == OP_MUL)      fin_res = acc_q;
    else if (op_q > OP_MACR) fin_res = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q <= '0; lm_q <= '0; vp_q <= 1'b0; sat_q <= 1'b0; clr_q <= 1'b0;
      cnt_q <= '0; nbits_q <= '0;
      a_q <= '0; b_q <= '0; c_q <= '0; acc_q <= '0; run_q <= '0;
      peout <= '0; out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q <= op; lm_q <= lm_in; vp_q <= vp; sat_q <= sat; clr_q <= clr;
          cnt_q <= n_in; nbits_q <= n_in;
          a_q <= opA; b_q <= opB; c_q <= opC; acc_q <= '0;
        end
        SHIFT: begin
          acc_q <= acc_n;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        FIN: begin
          peout     <= fin_res;
          out_valid <= 1'b1;
          if (op_q == OP_MACR) run_q <= fin_res;
        end
        OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
